// File: rtl/trig_pkg.sv
// Shared constants for the trigger-input conditioner: FSM encoding, default
// widths and register-bank offsets.
package trig_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_QUAL     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF  = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  localparam int FILT_W_DEF = 8;
  localparam int HOLD_W_DEF = 16;
  localparam int FB_W_DEF   = 8;
  localparam int CNT_W_DEF  = 32;

  localparam logic [7:0] REG_FILTLEN = 8'h00;
  localparam logic [7:0] REG_HOLDOFF = 8'h04;
  localparam logic [7:0] REG_FBLEN   = 8'h08;
  localparam logic [7:0] REG_CNTCLR  = 8'h0C;
  localparam logic [7:0] REG_TRIGCNT = 8'h10;
  localparam logic [7:0] REG_REJCNT  = 8'h14;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/trig_in_conditioner.sv
// External trigger conditioner: sync, glitch filter, one-shot trigger, hold-off
// re-arm, stretched feedback pulse and saturating event counters.
module trig_in_conditioner
  import trig_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int FB_W   = FB_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              io_clk,
  input  logic              io_rst,
  input  logic              io_pulseIn,
  input  logic              io_en,
  input  logic [FILT_W-1:0] io_filtLen,
  input  logic [HOLD_W-1:0] io_holdoff,
  input  logic [FB_W-1:0]   io_fbLen,
  input  logic              io_cntClr,
  output logic              io_trig,
  output logic              io_fbOut,
  output logic              io_busy,
  output logic [CNT_W-1:0]  io_trigCnt,
  output logic [CNT_W-1:0]  io_rejCnt
);
  logic              s, s_d, rise, fire, rej;
  logic [1:0]        state, state_nxt;
  logic [FILT_W-1:0] qcnt;
  logic [HOLD_W-1:0] hcnt;
  logic [FB_W-1:0]   fcnt;

  sync_2ff #(.W(1)) u_sync (
    .clk (io_clk),
    .rst (io_rst),
    .d   (io_pulseIn),
    .q   (s)
  );

  assign rise = s & ~s_d;
  // States are exclusive, so fire and rej never coincide.
  assign fire = io_en & s & (((state == ST_IDLE) & (io_filtLen == '0)) |
                             ((state == ST_QUAL) & (qcnt == io_filtLen)));
  assign rej  = io_en & (((state == ST_QUAL) & ~s) |
                         ((state == ST_HOLDOFF) & rise));

  always_comb begin
    state_nxt = state;
    if (!io_en) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:    if (s) state_nxt = (io_filtLen == '0) ? ST_HOLDOFF : ST_QUAL;
        ST_QUAL:    if (!s) state_nxt = ST_IDLE;
                    else if (qcnt == io_filtLen) state_nxt = ST_HOLDOFF;
        ST_HOLDOFF: if (hcnt == '0) state_nxt = s ? ST_WAIT_LOW : ST_IDLE;
        default:    if (!s) state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      s_d      <= 1'b0;
      state    <= ST_IDLE;
      io_busy  <= 1'b0;
      io_trig  <= 1'b0;
      io_fbOut <= 1'b0;
      qcnt     <= '0;
      hcnt     <= '0;
      fcnt     <= '0;
    end else begin
      s_d     <= s;
      state   <= state_nxt;
      io_busy <= (state_nxt != ST_IDLE);
      io_trig <= fire;
      if (!io_en) begin
        qcnt     <= '0;
        hcnt     <= '0;
        fcnt     <= '0;
        io_fbOut <= 1'b0;
      end else begin
        if (state == ST_IDLE) qcnt <= FILT_W'(1);
        else if (state == ST_QUAL) qcnt <= qcnt + FILT_W'(1);

        if (fire) hcnt <= io_holdoff;
        else if (state == ST_HOLDOFF && hcnt != '0) hcnt <= hcnt - HOLD_W'(1);

        // A fire during an active pulse reloads the stretch counter.
        if (fire && io_fbLen != '0) begin
          io_fbOut <= 1'b1;
          fcnt     <= io_fbLen - FB_W'(1);
        end else if (fcnt != '0) begin
          fcnt <= fcnt - FB_W'(1);
        end else begin
          io_fbOut <= 1'b0;
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      io_trigCnt <= '0;
      io_rejCnt  <= '0;
    end else if (io_cntClr) begin
      io_trigCnt <= '0;
      io_rejCnt  <= '0;
    end else begin
      if (fire && io_trigCnt != '1) io_trigCnt <= io_trigCnt + CNT_W'(1);
      if (rej && io_rejCnt != '1)   io_rejCnt  <= io_rejCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_trig_in_conditioner.sv
// Directed bench for trig_in_conditioner, built with 4-bit counters so that
// saturation is reachable in a short run.
module tb_trig_in_conditioner;
  logic        clk = 1'b0;
  logic        rst, pin, en, clr;
  logic [7:0]  filt;
  logic [15:0] hold;
  logic [7:0]  fbl;
  logic        trig, fbo, busy;
  logic [3:0]  tcnt, rcnt;
  int checks = 0, failures = 0;
  int trig_n = 0, fb_n = 0;

  trig_in_conditioner #(.FILT_W(8), .HOLD_W(16), .FB_W(8), .CNT_W(4)) dut (
    .io_clk     (clk),
    .io_rst     (rst),
    .io_pulseIn (pin),
    .io_en      (en),
    .io_filtLen (filt),
    .io_holdoff (hold),
    .io_fbLen   (fbl),
    .io_cntClr  (clr),
    .io_trig    (trig),
    .io_fbOut   (fbo),
    .io_busy    (busy),
    .io_trigCnt (tcnt),
    .io_rejCnt  (rcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    trig_n += int'(trig);
    fb_n   += int'(fbo);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_cnt();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk(tag, busy, 0);
  endtask

  initial begin
    rst = 1'b1; pin = 1'b0; en = 1'b0; clr = 1'b0;
    filt = '0; hold = '0; fbl = '0;
    #12;
    chk("rst_trig", trig, 0);
    chk("rst_fb", fbo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcnt", tcnt, 0);
    chk("rst_rcnt", rcnt, 0);
    rst = 1'b0;
    tick();

    // N=0 H=4 F=3, held high 10 cycles: one fire, 3-cycle feedback
    en = 1'b1; filt = 8'd0; hold = 16'd4; fbl = 8'd3;
    run(2);
    trig_n = 0; fb_n = 0;
    pin = 1'b1;
    tick(); chk("t1_e0_trig", trig, 0);
    tick(); chk("t1_e1_trig", trig, 0);
    tick(); chk("t1_e2_trig", trig, 1); chk("t1_e2_fb", fbo, 1); chk("t1_e2_busy", busy, 1);
    tick(); chk("t1_e3_trig", trig, 0); chk("t1_e3_fb", fbo, 1);
    tick(); chk("t1_e4_fb", fbo, 1);
    tick(); chk("t1_e5_fb", fbo, 0);
    run(4);
    pin = 1'b0;
    run(8);
    chk("t1_trig_n", trig_n, 1);
    chk("t1_fb_n", fb_n, 3);
    chk("t1_busy", busy, 0);
    chk("t1_tcnt", tcnt, 1);
    chk("t1_rcnt", rcnt, 0);

    // N=3: 2-cycle glitch rejected, 8-cycle pulse fires after edge 5
    clear_cnt();
    filt = 8'd3; hold = 16'd2; fbl = 8'd1;
    trig_n = 0;
    pin = 1'b1; run(2); pin = 1'b0; run(6);
    chk("t2_glitch_trig_n", trig_n, 0);
    chk("t2_glitch_rcnt", rcnt, 1);
    chk("t2_glitch_busy", busy, 0);
    pin = 1'b1;
    run(5); chk("t2_e4_trig", trig, 0);
    tick(); chk("t2_e5_trig", trig, 1);
    run(2); pin = 1'b0; run(6);
    chk("t2_trig_n", trig_n, 1);
    chk("t2_tcnt", tcnt, 1);
    chk("t2_rcnt", rcnt, 1);
    chk("t2_busy", busy, 0);

    // N=0 H=20 F=0: pulses 2-3-4 land in hold-off and are rejected
    clear_cnt();
    filt = 8'd0; hold = 16'd20; fbl = 8'd0;
    fb_n = 0;
    for (int k = 0; k < 4; k++) begin
      pin = 1'b1; run(2); pin = 1'b0; run(3);
    end
    wait_idle("t3_idle_a");
    chk("t3_tcnt_a", tcnt, 1);
    chk("t3_rcnt_a", rcnt, 3);
    pin = 1'b1; run(2); pin = 1'b0; run(6);
    wait_idle("t3_idle_b");
    chk("t3_tcnt_b", tcnt, 2);
    chk("t3_rcnt_b", rcnt, 3);
    chk("t3_fb_n", fb_n, 0);

    // Saturation: 17 fires into a 4-bit counter, then clear racing a fire
    clear_cnt();
    filt = 8'd0; hold = 16'd0; fbl = 8'd1;
    trig_n = 0;
    for (int k = 0; k < 17; k++) begin
      pin = 1'b1; run(2); pin = 1'b0; run(4);
    end
    chk("t4_trig_n", trig_n, 17);
    chk("t4_tcnt_sat", tcnt, 15);
    chk("t4_rcnt", rcnt, 0);
    pin = 1'b1; run(2);
    clr = 1'b1;
    tick();
    chk("t4_clr_trig", trig, 1);
    chk("t4_clr_tcnt", tcnt, 0);
    clr = 1'b0; pin = 1'b0;
    run(4);
    chk("t4_clr_tcnt_after", tcnt, 0);

    // Disable mid-QUAL (N=10)
    clear_cnt();
    filt = 8'd10; hold = 16'd20; fbl = 8'd10;
    trig_n = 0;
    pin = 1'b1; run(4);
    chk("t5_qual_busy", busy, 1);
    en = 1'b0;
    tick();
    chk("t5_qual_dis_busy", busy, 0);
    chk("t5_qual_dis_fb", fbo, 0);
    run(12);
    chk("t5_qual_trig_n", trig_n, 0);
    chk("t5_qual_tcnt", tcnt, 0);
    chk("t5_qual_rcnt", rcnt, 0);
    pin = 1'b0; run(3); en = 1'b1; run(3);
    chk("t5_qual_idle", busy, 0);

    // Disable mid-HOLDOFF with feedback active
    filt = 8'd0;
    trig_n = 0;
    pin = 1'b1; run(4);
    chk("t5_ho_busy", busy, 1);
    chk("t5_ho_fb", fbo, 1);
    en = 1'b0;
    tick();
    chk("t5_ho_dis_busy", busy, 0);
    chk("t5_ho_dis_fb", fbo, 0);
    chk("t5_ho_dis_trig", trig, 0);
    pin = 1'b0; run(3); pin = 1'b1; run(3); pin = 1'b0; run(4);
    chk("t5_ho_trig_n", trig_n, 1);
    chk("t5_ho_tcnt", tcnt, 1);
    chk("t5_ho_rcnt", rcnt, 0);
    en = 1'b1; run(3);

    // Async reset between edges while in HOLDOFF with feedback high
    clear_cnt();
    filt = 8'd0; hold = 16'd20; fbl = 8'd10;
    pin = 1'b1; run(4);
    chk("t6_pre_fb", fbo, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_trig", trig, 0);
    chk("t6_rst_fb", fbo, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tcnt", tcnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    trig_n = 0;
    run(2); chk("t6_e1_trig", trig, 0);
    tick(); chk("t6_e2_trig", trig, 1);
    run(30);
    chk("t6_trig_n", trig_n, 1);
    chk("t6_tcnt", tcnt, 1);
    pin = 1'b0; run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
